data_island_scheduler: RTL and testbench

//  Sequences one HDMI data island per video line in horizontal blanking: preamble, leading guard band, N packets, trailing guard band.

---
 rtl/data_island_scheduler_pkg.sv | 35 +++
 rtl/data_island_scheduler_if.sv | 23 ++
 rtl/data_island_scheduler_arbiter.sv | 10 +
 rtl/data_island_scheduler.sv | 156 +++++++++++++++
 tb/tb_data_island_scheduler.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/data_island_scheduler_pkg.sv
// rtl/data_island_scheduler_pkg.sv - HDMI data island period codes, sequencing lengths and FSM states
package data_island_scheduler_pkg;

    typedef enum logic [1:0] {
        PERIOD_CTRL     = 2'd0,
        PERIOD_PREAMBLE = 2'd1,
        PERIOD_GUARD    = 2'd2,
        PERIOD_DATA     = 2'd3
    } period_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_LGUARD,
        ST_DATA,
        ST_TGUARD
    } state_e;

    localparam int          PREAMBLE_LEN = 8;
    localparam int          GUARD_LEN    = 2;
    localparam int          PACKET_LEN   = 32;
    localparam logic [23:0] NULL_HEADER  = 24'h0;

    // Packets that fit between island start and the 12 cycles kept free for the video preamble.
    function automatic int calc_n_max(input int frame_width, input int screen_width,
                                      input int di_offset, input int max_packets);
        int avail;
        int n;
        avail = frame_width - screen_width - di_offset
              - (PREAMBLE_LEN + 2 * GUARD_LEN) - 12;
        n = (avail <= 0) ? 0 : avail / PACKET_LEN;
        return (n < max_packets) ? n : max_packets;
    endfunction

endpackage

// File: rtl/data_island_scheduler_if.sv
// rtl/data_island_scheduler_if.sv - packet source request/ack bus between sources and the scheduler
interface data_island_scheduler_if #(
    parameter int NUM_SRC = 4
);
    logic [NUM_SRC-1:0]     src_valid;
    logic [24*NUM_SRC-1:0]  src_header;
    logic [224*NUM_SRC-1:0] src_sub;
    logic [NUM_SRC-1:0]     src_ack;

    modport master (
        output src_valid,
        output src_header,
        output src_sub,
        input  src_ack
    );

    modport slave (
        input  src_valid,
        input  src_header,
        input  src_sub,
        output src_ack
    );
endinterface

// File: rtl/data_island_scheduler_arbiter.sv
// rtl/data_island_scheduler_arbiter.sv - fixed-priority one-hot arbiter, lowest index wins
module priority_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);
    // Two's complement isolates the lowest set bit.
    assign grant = req & (~req + N'(1));
endmodule

// File: rtl/data_island_scheduler.sv
// rtl/data_island_scheduler.sv - sequences one HDMI data island per line and arbitrates packet sources
module data_island_scheduler
    import data_island_scheduler_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int SCREEN_WIDTH = 1280,
    parameter int FRAME_WIDTH  = 1650,
    parameter int DI_OFFSET    = 4,
    parameter int MAX_PACKETS  = 18
) (
    input  logic                   clk_pixel,
    input  logic                   reset,
    input  logic [11:0]            cx,
    data_island_scheduler_if.slave src,
    output logic [23:0]            header,
    output logic [223:0]           sub,
    output logic                   data_island_period,
    output logic                   asm_reset,
    output logic [1:0]             period
);

    localparam int          N_MAX      = calc_n_max(FRAME_WIDTH, SCREEN_WIDTH, DI_OFFSET, MAX_PACKETS);
    localparam bit          HAS_BUDGET = (N_MAX > 0);
    localparam logic [4:0]  N_MAX_L    = 5'(N_MAX);
    localparam logic [11:0] ISLAND_CX  = 12'(SCREEN_WIDTH + DI_OFFSET);
    localparam logic [4:0]  PRE_LAST   = 5'(PREAMBLE_LEN - 1);
    localparam logic [4:0]  GUARD_LAST = 5'(GUARD_LEN - 1);
    localparam logic [4:0]  PKT_LAST   = 5'(PACKET_LEN - 1);

    state_e         state_q, state_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [4:0]     pkt_cnt_q, pkt_cnt_d;
    logic [23:0]    header_q, header_d;
    logic [223:0]   sub_q, sub_d;

    logic [NUM_SRC-1:0] grant;
    logic [NUM_SRC-1:0] ack;
    logic               any_valid;
    logic [23:0]        sel_header;
    logic [223:0]       sel_sub;
    period_e            period_raw;
    logic               dip_raw;

    priority_arbiter #(.N(NUM_SRC)) u_arbiter (
        .req   (src.src_valid),
        .grant (grant)
    );

    assign any_valid = |src.src_valid;

    always_comb begin
        sel_header = '0;
        sel_sub    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                sel_header = sel_header | src.src_header[24*i +: 24];
                sel_sub    = sel_sub    | src.src_sub[224*i +: 224];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        header_d   = header_q;
        sub_d      = sub_q;
        ack        = '0;
        period_raw = PERIOD_CTRL;
        dip_raw    = 1'b0;
        asm_reset  = reset;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (HAS_BUDGET && cx == ISLAND_CX && any_valid) begin
                    state_d = ST_PREAMBLE;
                end
            end
            ST_PREAMBLE: begin
                period_raw = PERIOD_PREAMBLE;
                cnt_d      = cnt_q + 5'd1;
                if (cnt_q == PRE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_LGUARD;
                end
            end
            ST_LGUARD: begin
                period_raw = PERIOD_GUARD;
                cnt_d      = cnt_q + 5'd1;
                if (cnt_q == GUARD_LAST) begin
                    // Assembler restarts here so its counter aligns with ours at the first data cycle.
                    asm_reset = 1'b1;
                    header_d  = any_valid ? sel_header : NULL_HEADER;
                    sub_d     = any_valid ? sel_sub : '0;
                    ack       = grant;
                    cnt_d     = '0;
                    pkt_cnt_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                period_raw = PERIOD_DATA;
                dip_raw    = 1'b1;
                cnt_d      = cnt_q + 5'd1;
                if (cnt_q == PKT_LAST) begin
                    pkt_cnt_d = pkt_cnt_q + 5'd1;
                    if ((pkt_cnt_q + 5'd1) < N_MAX_L && any_valid) begin
                        header_d = sel_header;
                        sub_d    = sel_sub;
                        ack      = grant;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_TGUARD;
                    end
                end
            end
            ST_TGUARD: begin
                period_raw = PERIOD_GUARD;
                cnt_d      = cnt_q + 5'd1;
                if (cnt_q == GUARD_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Reset silences the channel muxes and acks immediately, even before the state register clears.
    assign src.src_ack         = reset ? '0 : ack;
    assign period              = reset ? 2'(PERIOD_CTRL) : 2'(period_raw);
    assign data_island_period  = reset ? 1'b0 : dip_raw;
    assign header              = header_q;
    assign sub                 = sub_q;

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pkt_cnt_q <= '0;
            header_q  <= NULL_HEADER;
            sub_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pkt_cnt_q <= pkt_cnt_d;
            header_q  <= header_d;
            sub_q     <= sub_d;
        end
    end

endmodule

// File: tb/tb_data_island_scheduler.sv
// tb/tb_data_island_scheduler.sv - directed self-checking bench for data_island_scheduler
module tb_data_island_scheduler;

    localparam int NUM_SRC = 4;

    logic         clk_pixel = 1'b0;
    logic         reset = 1'b1;
    logic [11:0]  cx = 12'd0;
    logic [23:0]  header;
    logic [223:0] sub;
    logic         data_island_period;
    logic         asm_reset;
    logic [1:0]   period;

    data_island_scheduler_if #(.NUM_SRC(NUM_SRC)) src_if ();

    data_island_scheduler #(
        .NUM_SRC      (NUM_SRC),
        .SCREEN_WIDTH (1280),
        .FRAME_WIDTH  (1650),
        .DI_OFFSET    (4),
        .MAX_PACKETS  (18)
    ) u_dut (
        .clk_pixel          (clk_pixel),
        .reset              (reset),
        .cx                 (cx),
        .src                (src_if),
        .header             (header),
        .sub                (sub),
        .data_island_period (data_island_period),
        .asm_reset          (asm_reset),
        .period             (period)
    );

    always #5 clk_pixel = ~clk_pixel;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] hdr_of(input int i);
        return 24'hA50000 + 24'(i * 'h111);
    endfunction

    function automatic logic [223:0] sub_of(input int i);
        return {7{32'hC0DE0000 + 32'(i)}};
    endfunction

    function automatic int idx_of(input logic [NUM_SRC-1:0] onehot);
        for (int i = 0; i < NUM_SRC; i++) if (onehot[i]) return i;
        return 0;
    endfunction

    int n_pre, n_guard, n_data, n_dip, n_acks, n_asm, n_diff, hdr_err;
    int first_cx, last_cx, first_ack_cx, last_ack_cx, second_ack_cx, asm_cx, dpos;
    logic [NUM_SRC-1:0] ack_first, ack_second, ack_seen, drop_mask;
    logic [23:0]  pend_hdr, exp_hdr;
    logic [223:0] pend_sub, exp_sub;

    task automatic clear_stats();
        n_pre = 0; n_guard = 0; n_data = 0; n_dip = 0; n_acks = 0; n_asm = 0;
        n_diff = 0; hdr_err = 0; dpos = 0;
        first_cx = -1; last_cx = -1; first_ack_cx = -1; last_ack_cx = -1;
        second_ack_cx = -1; asm_cx = -1;
        ack_first = '0; ack_second = '0; ack_seen = '0;
        pend_hdr = '0; pend_sub = '0; exp_hdr = '0; exp_sub = '0;
    endtask

    always @(negedge clk_pixel) begin
        if (!reset) begin
            case (period)
                2'd1:    n_pre++;
                2'd2:    n_guard++;
                2'd3:    n_data++;
                default: ;
            endcase
            if (period != 2'd0) begin
                if (first_cx < 0) first_cx = int'(cx);
                last_cx = int'(cx);
            end
            if (data_island_period) n_dip++;
            if (asm_reset) begin
                n_asm++;
                asm_cx = int'(cx);
            end
            if (period == 2'd3) begin
                if (dpos == 0) begin
                    exp_hdr = pend_hdr;
                    exp_sub = pend_sub;
                end
                if (header !== exp_hdr || sub !== exp_sub) hdr_err++;
                dpos = (dpos + 1) % 32;
            end
            if (src_if.src_ack != '0) begin
                n_acks++;
                if (n_acks == 1) begin
                    ack_first    = src_if.src_ack;
                    first_ack_cx = int'(cx);
                end else if (n_acks == 2) begin
                    ack_second    = src_if.src_ack;
                    second_ack_cx = int'(cx);
                end
                if (src_if.src_ack != ack_first) n_diff++;
                last_ack_cx = int'(cx);
                pend_hdr    = hdr_of(idx_of(src_if.src_ack));
                pend_sub    = sub_of(idx_of(src_if.src_ack));
                ack_seen    = ack_seen | src_if.src_ack;
            end
        end
    end

    task automatic cycle();
        @(posedge clk_pixel);
        #1;
        cx = (cx == 12'd1649) ? 12'd0 : cx + 12'd1;
        src_if.src_valid = src_if.src_valid & ~(ack_seen & drop_mask);
        ack_seen = '0;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic start_line(input logic [NUM_SRC-1:0] valid, input logic [NUM_SRC-1:0] drop);
        src_if.src_valid = valid;
        drop_mask = drop;
        cx = 12'd1270;
        clear_stats();
    endtask

    initial begin
        bit reached;
        src_if.src_valid = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_if.src_header[24*i +: 24]   = hdr_of(i);
            src_if.src_sub[224*i +: 224]    = sub_of(i);
        end
        drop_mask = '0;
        clear_stats();

        // Reset state
        cycle();
        @(negedge clk_pixel);
        check_eq("rst_period", 256'(period), 256'(0));
        check_eq("rst_dip", 256'(data_island_period), 256'(0));
        check_eq("rst_ack", 256'(src_if.src_ack), 256'(0));
        check_eq("rst_asm_reset", 256'(asm_reset), 256'(1));
        check_eq("rst_header", 256'(header), 256'(0));
        check_eq("rst_sub", 256'(sub), 256'(0));
        reset = 1'b0;
        #1;
        check_eq("rst_release_asm", 256'(asm_reset), 256'(0));

        // No source valid: no island
        start_line(4'b0000, 4'b0000);
        run(400);
        check_eq("idle_nonctrl", 256'(n_pre + n_guard + n_data), 256'(0));
        check_eq("idle_dip", 256'(n_dip), 256'(0));
        check_eq("idle_acks", 256'(n_acks), 256'(0));

        // Source 0 held: full island of 10 packets
        start_line(4'b0001, 4'b0000);
        run(400);
        check_eq("s0_pre", 256'(n_pre), 256'(8));
        check_eq("s0_guard", 256'(n_guard), 256'(4));
        check_eq("s0_data", 256'(n_data), 256'(320));
        check_eq("s0_dip", 256'(n_dip), 256'(320));
        check_eq("s0_acks", 256'(n_acks), 256'(10));
        check_eq("s0_first_cx", 256'(first_cx), 256'(1285));
        check_eq("s0_last_cx", 256'(last_cx), 256'(1616));
        check_eq("s0_asm_cnt", 256'(n_asm), 256'(1));
        check_eq("s0_asm_cx", 256'(asm_cx), 256'(1294));
        check_eq("s0_first_ack_cx", 256'(first_ack_cx), 256'(1294));
        check_eq("s0_last_ack_cx", 256'(last_ack_cx), 256'(1582));
        check_eq("s0_hdr_err", 256'(hdr_err), 256'(0));

        // Sources 1 and 2, each dropping after its ack
        start_line(4'b0110, 4'b1111);
        run(400);
        check_eq("s12_first_ack", 256'(ack_first), 256'(4'b0010));
        check_eq("s12_second_ack", 256'(ack_second), 256'(4'b0100));
        check_eq("s12_second_cx", 256'(second_ack_cx), 256'(1326));
        check_eq("s12_acks", 256'(n_acks), 256'(2));
        check_eq("s12_data", 256'(n_data), 256'(64));
        check_eq("s12_len", 256'(last_cx - first_cx + 1), 256'(76));
        check_eq("s12_hdr_err", 256'(hdr_err), 256'(0));

        // Single packet then source drops
        start_line(4'b0001, 4'b0001);
        run(400);
        check_eq("one_acks", 256'(n_acks), 256'(1));
        check_eq("one_data", 256'(n_data), 256'(32));
        check_eq("one_last_cx", 256'(last_cx), 256'(1328));
        check_eq("one_hdr_err", 256'(hdr_err), 256'(0));

        // All sources held: source 0 always wins, packet budget 10
        start_line(4'b1111, 4'b0000);
        run(400);
        check_eq("all_acks", 256'(n_acks), 256'(10));
        check_eq("all_first_ack", 256'(ack_first), 256'(4'b0001));
        check_eq("all_other_grants", 256'(n_diff), 256'(0));
        check_eq("all_data", 256'(n_data), 256'(320));
        check_eq("all_margin", 256'(1649 - last_cx), 256'(33));

        // Valid rising one cycle after the island slot: no island this line
        start_line(4'b0000, 4'b0000);
        reached = 1'b0;
        for (int i = 0; i < 100 && !reached; i++) begin
            cycle();
            if (cx == 12'd1285) reached = 1'b1;
        end
        check_eq("late_reach", 256'(reached), 256'(1));
        src_if.src_valid = 4'b1111;
        run(300);
        check_eq("late_acks", 256'(n_acks), 256'(0));
        check_eq("late_nonctrl", 256'(n_pre + n_guard + n_data), 256'(0));
        src_if.src_valid = 4'b0000;
        run(20);

        // Reset during packet 3, then a clean island on the following line
        start_line(4'b1111, 4'b0000);
        reached = 1'b0;
        for (int i = 0; i < 400 && !reached; i++) begin
            cycle();
            if (n_data >= 70) reached = 1'b1;
        end
        check_eq("mid_reach", 256'(reached), 256'(1));
        reset = 1'b1;
        cycle();
        @(negedge clk_pixel);
        check_eq("mid_rst_period", 256'(period), 256'(0));
        check_eq("mid_rst_asm", 256'(asm_reset), 256'(1));
        check_eq("mid_rst_ack", 256'(src_if.src_ack), 256'(0));
        check_eq("mid_rst_dip", 256'(data_island_period), 256'(0));
        reset = 1'b0;
        clear_stats();
        run(2000);
        check_eq("after_rst_acks", 256'(n_acks), 256'(10));
        check_eq("after_rst_data", 256'(n_data), 256'(320));
        check_eq("after_rst_first_cx", 256'(first_cx), 256'(1285));
        check_eq("after_rst_hdr_err", 256'(hdr_err), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
